ram_nn_ctrl: RTL

Host-side sequencer for the RAM-based neural-network core. It accepts commands from a host and, in response, either streams weights into one layer's weight RAM or runs a full inference. An inference loads the input activation RAM, runs the req/ack handshake with the network, then reads the output-layer results back out as a stream. It sits between the host/DMA stream interfaces and the network's weight-select, activation-RAM, req/ack and output-RAM ports, and it is the only writer of those ports.

---
 rtl/ram_nn_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ram_nn_ctrl.sv
// Host-side sequencer for the RAM-based neural-network core: streams weights into a
// layer RAM, or runs an inference (activation load, req/ack, result read-out).
module ram_nn_ctrl #(
    parameter int InputWidth     = 49,
    parameter int DataWidth      = 8,
    parameter int NumLayers      = 3,
    parameter int NumOutputLayer = 4,
    parameter int AddrWidth      = $clog2(InputWidth),
    parameter int WgtAddrWidth   = 11,
    parameter int MaxWgtLen      = 1850
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic                         cmd_op_i,
    input  logic [$clog2(NumLayers)-1:0] cmd_layer_i,
    input  logic [WgtAddrWidth:0]        cmd_len_i,
    input  logic                         s_valid_i,
    output logic                         s_ready_o,
    input  logic [DataWidth-1:0]         s_data_i,
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic [DataWidth-1:0]         m_data_o,
    output logic                         m_last_o,
    output logic [$clog2(NumLayers)-1:0] nn_ram_index_o,
    output logic [WgtAddrWidth-1:0]      nn_wgt_addr_o,
    output logic                         nn_wgt_we_o,
    output logic [DataWidth-1:0]         nn_wgt_din_o,
    output logic [AddrWidth-1:0]         nn_actv_addr_o,
    output logic                         nn_actv_we_o,
    output logic [DataWidth-1:0]         nn_actv_din_o,
    output logic [AddrWidth-1:0]         nn_out_addr_o,
    input  logic [DataWidth-1:0]         nn_out_dout_i,
    output logic                         nn_req_o,
    input  logic                         nn_ack_i,
    output logic                         busy_o,
    output logic                         err_o
);

    localparam int LayerW = $clog2(NumLayers);
    localparam logic [LayerW:0]       LAYER_LIMIT = (LayerW+1)'(NumLayers);
    localparam logic [WgtAddrWidth:0] WGT_MAX     = (WgtAddrWidth+1)'(MaxWgtLen);
    localparam logic [WgtAddrWidth:0] WGT_ONE     = (WgtAddrWidth+1)'(1);
    localparam logic [AddrWidth:0]    ACT_LAST    = (AddrWidth+1)'(InputWidth-1);
    localparam logic [AddrWidth:0]    RES_LAST    = (AddrWidth+1)'(NumOutputLayer-1);
    localparam logic [AddrWidth:0]    ACT_ONE     = (AddrWidth+1)'(1);

    typedef enum logic [2:0] {
        IDLE, LD_WGT, LD_ACT, REQ, ACK_LO, RD_ADDR, RD_WAIT, OUT
    } state_t;

    state_t                  state_reg, state_next;
    logic [WgtAddrWidth:0]   wgt_cnt_reg, len_reg;
    // Shared: activation write address during LD_ACT, result index during read-out.
    logic [AddrWidth:0]      act_cnt_reg;
    logic [LayerW-1:0]       ram_index_reg;
    logic [WgtAddrWidth-1:0] wgt_addr_reg;
    logic                    wgt_we_reg;
    logic [DataWidth-1:0]    wgt_din_reg;
    logic [AddrWidth-1:0]    actv_addr_reg;
    logic                    actv_we_reg;
    logic [DataWidth-1:0]    actv_din_reg;
    logic [DataWidth-1:0]    m_data_reg;
    logic                    err_reg;
    logic                    cmd_bad;
    logic                    s_fire;

    assign cmd_bad = ~cmd_op_i && (({1'b0, cmd_layer_i} >= LAYER_LIMIT) ||
                                   (cmd_len_i == '0) || (cmd_len_i > WGT_MAX));
    assign s_fire  = s_valid_i && s_ready_o;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid_i) begin
                    if (cmd_op_i)      state_next = LD_ACT;
                    else if (!cmd_bad) state_next = LD_WGT;
                end
            end
            LD_WGT:  if (s_fire && (wgt_cnt_reg == len_reg - WGT_ONE)) state_next = IDLE;
            LD_ACT:  if (s_fire && (act_cnt_reg == ACT_LAST)) state_next = REQ;
            REQ:     if (nn_ack_i) state_next = ACK_LO;
            ACK_LO:  if (!nn_ack_i) state_next = RD_ADDR;
            RD_ADDR: state_next = RD_WAIT;
            RD_WAIT: state_next = OUT;
            OUT: begin
                if (m_ready_i) state_next = (act_cnt_reg == RES_LAST) ? IDLE : RD_ADDR;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg     <= IDLE;
            wgt_cnt_reg   <= '0;
            len_reg       <= '0;
            act_cnt_reg   <= '0;
            ram_index_reg <= '0;
            wgt_addr_reg  <= '0;
            wgt_we_reg    <= 1'b0;
            wgt_din_reg   <= '0;
            actv_addr_reg <= '0;
            actv_we_reg   <= 1'b0;
            actv_din_reg  <= '0;
            m_data_reg    <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wgt_we_reg  <= 1'b0;
            actv_we_reg <= 1'b0;
            err_reg     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid_i) begin
                        if (cmd_op_i) begin
                            act_cnt_reg <= '0;
                        end else if (cmd_bad) begin
                            err_reg <= 1'b1;
                        end else begin
                            ram_index_reg <= cmd_layer_i;
                            len_reg       <= cmd_len_i;
                            wgt_cnt_reg   <= '0;
                        end
                    end
                end
                LD_WGT: begin
                    if (s_fire) begin
                        wgt_we_reg   <= 1'b1;
                        wgt_addr_reg <= wgt_cnt_reg[WgtAddrWidth-1:0];
                        wgt_din_reg  <= s_data_i;
                        wgt_cnt_reg  <= wgt_cnt_reg + WGT_ONE;
                    end
                end
                LD_ACT: begin
                    if (s_fire) begin
                        actv_we_reg   <= 1'b1;
                        actv_addr_reg <= act_cnt_reg[AddrWidth-1:0];
                        actv_din_reg  <= s_data_i;
                        act_cnt_reg   <= act_cnt_reg + ACT_ONE;
                    end
                end
                ACK_LO:  if (!nn_ack_i) act_cnt_reg <= '0;
                RD_WAIT: m_data_reg <= nn_out_dout_i;
                OUT: begin
                    if (m_ready_i && (act_cnt_reg != RES_LAST)) act_cnt_reg <= act_cnt_reg + ACT_ONE;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready_o    = (state_reg == IDLE);
    assign busy_o         = (state_reg != IDLE);
    assign s_ready_o      = (state_reg == LD_WGT) || (state_reg == LD_ACT);
    assign nn_req_o       = (state_reg == REQ);
    assign m_valid_o      = (state_reg == OUT);
    assign m_last_o       = (state_reg == OUT) && (act_cnt_reg == RES_LAST);
    assign m_data_o       = m_data_reg;
    assign err_o          = err_reg;
    assign nn_ram_index_o = ram_index_reg;
    assign nn_wgt_addr_o  = wgt_addr_reg;
    assign nn_wgt_we_o    = wgt_we_reg;
    assign nn_wgt_din_o   = wgt_din_reg;
    assign nn_actv_addr_o = actv_addr_reg;
    assign nn_actv_we_o   = actv_we_reg;
    assign nn_actv_din_o  = actv_din_reg;
    // The output RAM has a registered read, so the address must be valid in RD_ADDR.
    assign nn_out_addr_o  = ((state_reg == RD_ADDR) || (state_reg == RD_WAIT)) ?
                            act_cnt_reg[AddrWidth-1:0] : '0;

endmodule
